// File: rtl/mbinit_sb_tx_arbiter.sv
// Sideband TX arbiter for the MBINIT substate modules.
// Grants one requester at a time (round-robin), forwards its message to the
// sideband TX encoder as a one-cycle strobe, tracks sideband busy and closes
// the owner's send with a falling-edge-busy pulse.
module mbinit_sb_tx_arbiter #(
  parameter int N_REQ   = 6,
  parameter int MSG_W   = 4,
  parameter int ID_W    = 3,
  parameter int BUSY_TO = 15
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*MSG_W-1:0] i_req_msg,
  input  logic                   i_sb_busy,
  output logic                   o_sb_valid,
  output logic [MSG_W-1:0]       o_sb_msg,
  output logic [ID_W-1:0]        o_sb_src_id,
  output logic [N_REQ-1:0]       o_grant,
  output logic [N_REQ-1:0]       o_falling_edge_busy,
  output logic                   o_timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TO + 1);
  localparam logic [CNT_W-1:0] BUSY_TO_C = CNT_W'(BUSY_TO);
  localparam logic [ID_W:0]    N_REQ_C   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              busy_q;
  logic              sb_valid_q, sb_valid_d;
  logic [MSG_W-1:0]  sb_msg_q, sb_msg_d;
  logic [ID_W-1:0]   sb_src_id_q, sb_src_id_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  feb_q, feb_d;
  logic              timeout_q, timeout_d;

  logic [MSG_W-1:0]  req_msg_arr [N_REQ];
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W:0]     rr_idx;
  logic              owner_vld;
  logic              busy_fall;

  for (genvar k = 0; k < N_REQ; k++) begin : g_msg
    assign req_msg_arr[k] = i_req_msg[k*MSG_W +: MSG_W];
  end

  assign owner_vld = i_req_valid[owner_q];
  assign busy_fall = busy_q & ~i_sb_busy;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      rr_idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (rr_idx >= N_REQ_C) rr_idx = rr_idx - N_REQ_C;
      if (i_req_valid[rr_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_idx[ID_W-1:0];
      end
    end
  end

  // Transaction FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    sb_valid_d  = 1'b0;
    sb_msg_d    = '0;
    sb_src_id_d = '0;
    grant_d     = grant_q;
    feb_d       = '0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !i_sb_busy) begin
          state_d          = ISSUE;
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          sb_valid_d       = 1'b1;
          sb_msg_d         = req_msg_arr[win_idx];
          sb_src_id_d      = win_idx;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
        drop_d  = 1'b0;
      end
      WAIT_BUSY: begin
        // Busy rise wins over both abort and timeout in the same cycle.
        if (i_sb_busy) begin
          state_d = WAIT_DONE;
          drop_d  = ~owner_vld;
        end else if (!owner_vld) begin
          state_d = RELEASE;
          grant_d = '0;
        end else if (cnt_q == BUSY_TO_C) begin
          state_d   = RELEASE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // An owner that drops valid here still waits for the fall, but gets no pulse.
        if (!owner_vld) drop_d = 1'b1;
        if (busy_fall) begin
          state_d = RELEASE;
          grant_d = '0;
          if (owner_vld && !drop_q) begin
            feb_d = grant_q;
            ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, pointer and output registers; reset aborts any transaction silently.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      sb_valid_q  <= 1'b0;
      sb_msg_q    <= '0;
      sb_src_id_q <= '0;
      grant_q     <= '0;
      feb_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      busy_q      <= i_sb_busy;
      sb_valid_q  <= sb_valid_d;
      sb_msg_q    <= sb_msg_d;
      sb_src_id_q <= sb_src_id_d;
      grant_q     <= grant_d;
      feb_q       <= feb_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_sb_valid          = sb_valid_q;
  assign o_sb_msg            = sb_msg_q;
  assign o_sb_src_id         = sb_src_id_q;
  assign o_grant             = grant_q;
  assign o_falling_edge_busy = feb_q;
  assign o_timeout_err       = timeout_q;

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Scoreboard bench for mbinit_sb_tx_arbiter: stimulus pushes expected
// events (issue / completion / timeout, with the cycle they must appear in),
// an independent monitor pops and compares whenever the DUT emits one.
module tb_mbinit_sb_tx_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [5:0]  req_valid;
  logic [23:0] req_msg;
  logic        sb_busy;
  logic        o_sb_valid;
  logic [3:0]  o_sb_msg;
  logic [2:0]  o_sb_src_id;
  logic [5:0]  o_grant;
  logic [5:0]  o_feb;
  logic        o_to;

  mbinit_sb_tx_arbiter #(
    .N_REQ(6), .MSG_W(4), .ID_W(3), .BUSY_TO(15)
  ) dut (
    .CLK                 (CLK),
    .rst_n               (rst_n),
    .i_req_valid         (req_valid),
    .i_req_msg           (req_msg),
    .i_sb_busy           (sb_busy),
    .o_sb_valid          (o_sb_valid),
    .o_sb_msg            (o_sb_msg),
    .o_sb_src_id         (o_sb_src_id),
    .o_grant             (o_grant),
    .o_falling_edge_busy (o_feb),
    .o_timeout_err       (o_to)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         kind;   // 0 issue, 1 completion pulse, 2 timeout
    int         cyc;
    logic [5:0] vec;
    logic [5:0] gnt;
    logic [3:0] msg;
    logic [2:0] id;
    logic       to;
  } ev_t;

  ev_t q[$];
  ev_t mon_a, mon_e;

  function automatic void push(input int kind, input int c, input int id, input logic [3:0] msg);
    ev_t e;
    e.kind = kind; e.cyc = c; e.vec = '0; e.gnt = '0; e.msg = '0; e.id = '0; e.to = 1'b0;
    case (kind)
      0: begin e.gnt = 6'b1 << id; e.msg = msg; e.id = 3'(id); end
      1: e.vec = 6'b1 << id;
      default: e.to = 1'b1;
    endcase
    q.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: any DUT output event is matched against the head of the queue.
  always @(negedge CLK) begin
    if (rst_n) begin
      if (o_sb_valid || (o_feb != 6'b0) || o_to) begin
        mon_a.kind = o_sb_valid ? 0 : ((o_feb != 6'b0) ? 1 : 2);
        mon_a.cyc  = cyc;
        mon_a.vec  = o_feb;
        mon_a.gnt  = o_grant;
        mon_a.msg  = o_sb_msg;
        mon_a.id   = o_sb_src_id;
        mon_a.to   = o_to;
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: kind %0d cyc %0d feb %b grant %b, expected no event",
                   mon_a.kind, mon_a.cyc, mon_a.vec, mon_a.gnt);
        end else begin
          mon_e = q.pop_front();
          if (mon_a.kind != mon_e.kind || mon_a.cyc != mon_e.cyc || mon_a.vec !== mon_e.vec ||
              mon_a.gnt !== mon_e.gnt || mon_a.msg !== mon_e.msg || mon_a.id !== mon_e.id ||
              mon_a.to !== mon_e.to) begin
            n_err++;
            $display("FAIL event: got kind %0d cyc %0d feb %b grant %b msg %h id %0d to %b, expected kind %0d cyc %0d feb %b grant %b msg %h id %0d to %b",
                     mon_a.kind, mon_a.cyc, mon_a.vec, mon_a.gnt, mon_a.msg, mon_a.id, mon_a.to,
                     mon_e.kind, mon_e.cyc, mon_e.vec, mon_e.gnt, mon_e.msg, mon_e.id, mon_e.to);
          end
        end
      end else begin
        n_vec++;
        if ({o_sb_msg, o_sb_src_id} !== 7'b0) begin
          n_err++;
          $display("FAIL idle_msg_zero: got msg %h id %0d, expected 0/0 (cycle %0d)",
                   o_sb_msg, o_sb_src_id, cyc);
        end
      end
    end
  end

  // One complete transaction: issue next cycle, busy 3 cycles, completion, owner drops.
  task automatic serve(input int id, input logic [3:0] msg);
    int k;
    k = cyc;
    push(0, k + 1, id, msg);
    step(); step();
    sb_busy = 1'b1;
    step(); step();
    chk("grant_held", 32'(o_grant), 32'(6'b1 << id));
    step();
    sb_busy = 1'b0;
    push(1, k + 6, id, 4'h0);
    step();
    req_valid[id] = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int k;
    rst_n     = 1'b0;
    req_valid = '0;
    sb_busy   = 1'b0;
    req_msg   = {4'h3, 4'h9, 4'hC, 4'h1, 4'h6, 4'hA};
    #1;
    chk("reset_outputs", 32'({o_sb_valid, o_sb_msg, o_sb_src_id, o_grant, o_feb, o_to}), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Round robin from pointer 0, then again after re-asserting.
    req_valid = 6'b101001;
    serve(0, 4'hA); serve(3, 4'hC); serve(5, 4'h3);
    req_msg[3:0] = 4'h5;
    req_valid = 6'b101001;
    serve(0, 4'h5); serve(3, 4'hC); serve(5, 4'h3);

    // Single send from req 2; pointer then sits at 3, so 3 beats 0.
    req_valid[2] = 1'b1;
    serve(2, 4'h1);
    req_valid = 6'b001001;
    serve(3, 4'hC); serve(0, 4'h5);

    // Busy gating: no issue while a foreign busy is high.
    sb_busy = 1'b1;
    req_valid[1] = 1'b1;
    repeat (4) step();
    chk("gated_no_grant", 32'(o_grant), 32'h0);
    sb_busy = 1'b0;
    serve(1, 4'h6);

    // Timeout: 16 cycles with no busy; pointer stays at 2, so 3 beats 5.
    k = cyc;
    req_valid[4] = 1'b1;
    push(0, k + 1, 4, 4'h9);
    push(2, k + 18, 0, 4'h0);
    repeat (18) step();
    chk("timeout_grant_clr", 32'(o_grant), 32'h0);
    req_valid[4] = 1'b0;
    step();
    req_valid = 6'b101000;
    serve(3, 4'hC); serve(5, 4'h3);

    // Abort in WAIT_BUSY: no pulse, pointer stays 0.
    k = cyc;
    req_valid[1] = 1'b1;
    push(0, k + 1, 1, 4'h6);
    step(); step();
    req_valid[1] = 1'b0;
    step();
    chk("abort_busy_grant_clr", 32'(o_grant), 32'h0);
    step();

    // Abort in WAIT_DONE: grant held until the busy fall, pulse suppressed.
    k = cyc;
    req_valid = 6'b001001;
    push(0, k + 1, 0, 4'h5);
    step(); step();
    sb_busy = 1'b1;
    step();
    req_valid[0] = 1'b0;
    step(); step();
    chk("abort_done_grant_held", 32'(o_grant), 32'h1);
    sb_busy = 1'b0;
    step();
    chk("abort_done_grant_clr", 32'(o_grant), 32'h0);
    step();
    serve(3, 4'hC);

    // Reset during WAIT_DONE: outputs clear at once, pointer back to 0.
    k = cyc;
    req_valid = 6'b100100;
    push(0, k + 1, 5, 4'h3);
    step(); step();
    sb_busy = 1'b1;
    step(); step();
    chk("pre_reset_grant", 32'(o_grant), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({o_sb_valid, o_sb_msg, o_sb_src_id, o_grant, o_feb, o_to}), 32'h0);
    sb_busy = 1'b0;
    step(); step();
    rst_n = 1'b1;
    serve(2, 4'h1); serve(5, 4'h3);

    repeat (3) step();
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mbinit_sb_tx_arbiter.md
Name: mbinit_sb_tx_arbiter

Overview:
- Shares the single sideband TX path among the MBINIT substate modules (PARAM, CAL, REPAIRCLK, REPAIRVAL, REVERSALMB, REPAIRMB).
- Each requester presents a 4-bit message plus a level valid. The arbiter grants one requester at a time, round-robin.
- It forwards the message to sideband TX as a single-cycle strobe, tracks sideband busy, and returns a per-requester falling-edge-busy pulse that closes that requester's send.
- Sits between the MBINIT substate modules and the sideband TX encoder.

Parameters:
- N_REQ, 6: number of requesters.
- MSG_W, 4: message code width.
- ID_W, 3: source-ID width; must satisfy 2^ID_W >= N_REQ.
- BUSY_TO, 15: maximum cycles to wait for busy to rise after issue.

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  N_REQ  per-requester send request, level
- i_req_msg  in  N_REQ*MSG_W  requester k message at bits [k*MSG_W +: MSG_W]
- i_sb_busy  in  1  sideband TX busy
- o_sb_valid  out  1  one-cycle strobe to sideband TX
- o_sb_msg  out  MSG_W  message forwarded with the strobe
- o_sb_src_id  out  ID_W  index of the granted requester
- o_grant  out  N_REQ  one-hot owner, held for the whole transaction
- o_falling_edge_busy  out  N_REQ  one-hot one-cycle completion pulse to the owner
- o_timeout_err  out  1  one-cycle pulse when busy never rises

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is CLK.
  - All outputs are 0; state = IDLE.
  - Round-robin pointer = 0; busy_q = 0; timeout counter = 0.
  - Reset mid-transaction aborts immediately with no pulses.
- All outputs are registered. busy_q is i_sb_busy delayed by one cycle. Falling edge = busy_q & ~i_sb_busy.
- IDLE:
  - Enters ISSUE when at least one i_req_valid is set and i_sb_busy = 0.
  - Winner = first valid requester scanning from the pointer upward, wrapping from N_REQ-1 to 0.
  - Latch the winner's message and index; set o_grant.
  - If i_sb_busy = 1, no grant is made and the request waits.
- ISSUE (1 cycle):
  - o_sb_valid = 1, with o_sb_msg and o_sb_src_id from the latched values.
  - Latency: valid sampled at edge t gives o_sb_valid high during cycle t+1.
  - Next state: WAIT_BUSY; counter cleared.
- WAIT_BUSY:
  - i_sb_busy = 1 -> WAIT_DONE.
  - Owner valid drops -> RELEASE, no completion pulse.
  - Counter reaches BUSY_TO -> o_timeout_err pulse, RELEASE, no completion pulse.
  - Busy rise takes priority over timeout in the same cycle.
- WAIT_DONE:
  - On falling edge: o_falling_edge_busy[owner] = 1 for one cycle; o_grant clears in that same cycle.
  - Pointer = owner+1 modulo N_REQ; next state RELEASE.
  - If owner valid dropped during WAIT_DONE, still wait for the falling edge but suppress the pulse.
- RELEASE (1 cycle):
  - No arbitration, so the released owner can deassert valid before the next IDLE evaluation.
  - Next state: IDLE.
- Other rules:
  - o_sb_msg and o_sb_src_id are 0 except during ISSUE.
  - A timeout or abort leaves the pointer unchanged.
  - Requests are never lost: a valid held through a foreign transaction is served later.
  - With all N_REQ requesters valid continuously, each is served once per N_REQ transactions.
  - Unreachable state encodings go to IDLE.

Test Plan:
- Single send:
  - Stimulus: req 2 valid, msg 4'b0001, busy = 0.
  - Response: o_grant = 6'b000100 and o_sb_valid = 1 with o_sb_msg = 4'b0001, o_sb_src_id = 2, one cycle after valid is sampled.
  - Then drive busy high for 5 cycles, then low. Response: o_falling_edge_busy = 6'b000100 for exactly 1 cycle, pointer = 3.
- Round robin:
  - Stimulus: reqs 0, 3 and 5 held valid; each requester drops its valid one cycle after its own completion pulse.
  - Response: grant order 0, 3, 5. Re-assert all three: order is again 0, 3, 5.
- Busy gating:
  - Stimulus: req 1 valid while i_sb_busy = 1 from a foreign source.
  - Response: no o_sb_valid; issue occurs in the cycle after busy deasserts is sampled.
- Timeout:
  - Stimulus: issue with busy held 0 for 16 cycles.
  - Response: o_timeout_err pulses once, no completion pulse, pointer unchanged, arbiter back in IDLE 2 cycles later.
- Abort:
  - Stimulus: owner valid drops in WAIT_BUSY.
  - Response: RELEASE then IDLE, zero pulses.
  - Stimulus: owner valid drops in WAIT_DONE.
  - Response: completion pulse suppressed on the busy fall.
- Reset mid-transaction:
  - Stimulus: rst_n low during WAIT_DONE.
  - Response: all outputs 0 asynchronously; after release, first grant goes to the lowest-index valid requester (pointer = 0).
